icache_responder: RTL



---
 rtl/icache_responder_pkg.sv | 41 ++++
 rtl/icache_way.sv | 65 ++++++
 rtl/icache_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_responder_pkg
//  Description : Shared fetch-side cache definitions: CACOP/lookup opcodes,
//                refill FSM states, geometry constants and a line word
//                selector used by the responder and its way arrays.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_responder_pkg;

    localparam int IC_WAYS       = 2;
    localparam int IC_SETS       = 256;
    localparam int IC_LINE_WORDS = 4;
    localparam int IC_TAG_W      = 20;
    localparam int IC_SET_W      = 8;
    localparam int IC_OFF_W      = 2;
    localparam int IC_LINE_W     = IC_LINE_WORDS * 32;

    typedef enum logic [2:0] {
        IC_NOP      = 3'd0,
        IC_LOAD     = 3'd1,
        IC_IDX_INIT = 3'd2,
        IC_IDX_INV  = 3'd3,
        IC_HIT_INV  = 3'd4
    } icache_op_t;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_RECV = 2'd2,
        IC_DONE = 2'd3
    } ic_state_t;

    // Word 0 of a line sits in the least significant 32 bits.
    function automatic logic [31:0] ic_line_word(input logic [IC_LINE_W-1:0] line,
                                                 input logic [IC_OFF_W-1:0]  off);
        return line[off*32 +: 32];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_way.sv
`default_nettype none
// ============================================================================
//  Module      : icache_way
//  Description : One way of the instruction cache: tag, valid and data
//                arrays held in flops. Combinational read, synchronous
//                full-line write (which also sets valid) and a per-set
//                valid clear. Only the valid bits are reset.
//  Ports       : clk, rst_n       clock, async active-low reset
//                rd_set           set being looked up in stage 2
//                rd_tag/rd_valid/rd_line  lookup results
//                wr_en/wr_set/wr_tag/wr_line  refill line write
//                clr_en/clr_set   invalidate one set
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_way
    import icache_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IC_SET_W-1:0]  rd_set,
    output logic [IC_TAG_W-1:0]  rd_tag,
    output logic                 rd_valid,
    output logic [IC_LINE_W-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [IC_SET_W-1:0]  wr_set,
    input  logic [IC_TAG_W-1:0]  wr_tag,
    input  logic [IC_LINE_W-1:0] wr_line,
    input  logic                 clr_en,
    input  logic [IC_SET_W-1:0]  clr_set
);

    logic [IC_TAG_W-1:0]  r_tag  [IC_SETS];
    logic [IC_LINE_W-1:0] r_data [IC_SETS];
    logic [IC_SETS-1:0]   r_valid;

    // Tag and data contents are meaningless until valid is set, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_set]  <= wr_tag;
            r_data[wr_set] <= wr_line;
        end
    end

    // A write and a clear never coincide (refill and CACOP are exclusive);
    // the write is placed last so it would win regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            if (clr_en) begin
                r_valid[clr_set] <= 1'b0;
            end
            if (wr_en) begin
                r_valid[wr_set] <= 1'b1;
            end
        end
    end

    assign rd_tag   = r_tag[rd_set];
    assign rd_valid = r_valid[rd_set];
    assign rd_line  = r_data[rd_set];

endmodule
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icache_responder
//  Description : Responder end of the fetch-side cache interface. 2-way,
//                256-set, 16-byte-line VIPT instruction cache with 1-bit LRU.
//                Stage 1 registers the lookup; stage 2 reads the flop arrays,
//                answers hits the next cycle, runs CACOP invalidates, and
//                hands misses / uncached fetches to a refill FSM.
//  Ports       : clk, rst_n                     clock, async active-low reset
//                is_icache_stall                hold stage 2, accept nothing
//                icache_idx/op/is_cached/pa     stage-1 request
//                icache_ready/icache_data       stage-2 response
//                rd_req/rd_type/rd_addr/rd_rdy  memory read request
//                ret_valid/ret_last/ret_data    memory return beats
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int WAYS       = IC_WAYS,        // fixed at 2 (1-bit LRU)
    parameter int LINE_WORDS = IC_LINE_WORDS,  // fixed at 4
    parameter int SETS       = IC_SETS         // fixed at 256
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_icache_stall,
    input  logic [11:0] icache_idx,
    input  logic [2:0]  icache_op,
    input  logic        icache_is_cached,
    input  logic [31:0] icache_pa,
    output logic        icache_ready,
    output logic [31:0] icache_data,
    output logic        rd_req,
    output logic        rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    localparam int BEAT_W = $clog2(LINE_WORDS);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    ic_state_t                        r_state;
    ic_state_t                        w_next_state;
    logic                             r_s2_valid;
    icache_op_t                       r_s2_op;
    logic [11:2]                      r_s2_idx;
    logic [31:0]                      r_s2_pa;
    logic                             r_s2_cached;
    logic [BEAT_W-1:0]                r_beat;
    logic [LINE_WORDS-1:0][31:0]      r_buf;
    logic [SETS-1:0]                  r_lru;      // way to evict next

    // ---------------------------------------------------------------------
    // Stage-2 lookup
    // ---------------------------------------------------------------------
    logic [IC_SET_W-1:0]  w_set;
    logic [IC_OFF_W-1:0]  w_off;
    logic [IC_TAG_W-1:0]  w_way_tag  [WAYS];
    logic [IC_LINE_W-1:0] w_way_line [WAYS];
    logic [WAYS-1:0]      w_way_valid;
    logic [WAYS-1:0]      w_hit;
    logic                 w_any_hit;
    logic                 w_hit_way;
    logic [31:0]          w_hit_word;
    logic                 w_victim;

    logic                 w_accept;
    logic                 w_fill_we;
    logic [WAYS-1:0]      w_wr_en;
    logic [WAYS-1:0]      w_clr_en;
    logic                 w_lru_we;
    logic                 w_lru_val;
    logic                 w_unused;

    assign w_set      = r_s2_idx[11:4];
    assign w_off      = r_s2_idx[3:2];
    assign w_any_hit  = |w_hit;
    assign w_hit_way  = !w_hit[0];
    assign w_hit_word = ic_line_word(w_way_line[w_hit_way], w_off);
    assign w_victim   = r_lru[w_set];
    assign w_unused   = ^icache_idx[1:0];

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            icache_way u_way (
                .clk      (clk),
                .rst_n    (rst_n),
                .rd_set   (w_set),
                .rd_tag   (w_way_tag[g]),
                .rd_valid (w_way_valid[g]),
                .rd_line  (w_way_line[g]),
                .wr_en    (w_wr_en[g]),
                .wr_set   (w_set),
                .wr_tag   (r_s2_pa[31:12]),
                .wr_line  (r_buf),
                .clr_en   (w_clr_en[g]),
                .clr_set  (w_set)
            );
            assign w_hit[g] = w_way_valid[g] && (w_way_tag[g] == r_s2_pa[31:12]);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // FSM next state, responses and array control
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        icache_ready = 1'b0;
        icache_data  = '0;
        rd_req       = 1'b0;
        rd_type      = 1'b0;
        rd_addr      = '0;
        w_accept     = 1'b0;
        w_fill_we    = 1'b0;
        w_clr_en     = '0;
        w_lru_we     = 1'b0;
        w_lru_val    = 1'b0;

        case (r_state)
            IC_IDLE: begin
                w_accept = !is_icache_stall;
                if (r_s2_valid) begin
                    case (r_s2_op)
                        IC_LOAD: begin
                            if (r_s2_cached && w_any_hit) begin
                                icache_ready = 1'b1;
                                icache_data  = w_hit_word;
                                w_lru_we     = 1'b1;
                                w_lru_val    = !w_hit_way;
                            end else begin
                                // Stage 2 must hold its request across the refill.
                                w_accept     = 1'b0;
                                w_next_state = IC_REQ;
                            end
                        end
                        IC_IDX_INIT, IC_IDX_INV: begin
                            icache_ready           = 1'b1;
                            w_clr_en[r_s2_pa[0]]   = 1'b1;
                        end
                        IC_HIT_INV: begin
                            icache_ready = 1'b1;
                            w_clr_en     = w_hit;
                        end
                        default: begin
                            icache_ready = 1'b1;
                        end
                    endcase
                end
            end
            IC_REQ: begin
                rd_req  = 1'b1;
                rd_type = r_s2_cached;
                rd_addr = r_s2_cached ? {r_s2_pa[31:4], 4'b0000} : r_s2_pa;
                if (rd_rdy) begin
                    w_next_state = IC_RECV;
                end
            end
            IC_RECV: begin
                if (ret_valid && ret_last) begin
                    w_next_state = IC_DONE;
                end
            end
            IC_DONE: begin
                icache_ready = 1'b1;
                icache_data  = r_s2_cached ? r_buf[w_off] : r_buf[0];
                // The line is committed only on the leaving edge so a stalled
                // DONE does not re-pick the victim after LRU has flipped.
                if (!is_icache_stall) begin
                    w_next_state = IC_IDLE;
                    w_accept     = 1'b1;
                    if (r_s2_cached) begin
                        w_fill_we = 1'b1;
                        w_lru_we  = 1'b1;
                        w_lru_val = !w_victim;
                    end
                end
            end
            default: begin
                w_next_state = IC_IDLE;
            end
        endcase

        w_wr_en           = '0;
        w_wr_en[w_victim] = w_fill_we;
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IC_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_op     <= IC_NOP;
            r_s2_idx    <= '0;
            r_s2_pa     <= '0;
            r_s2_cached <= 1'b0;
        end else if (w_accept) begin
            r_s2_valid  <= (icache_op != 3'd0);
            r_s2_op     <= icache_op_t'(icache_op);
            r_s2_idx    <= icache_idx[11:2];
            r_s2_pa     <= icache_pa;
            r_s2_cached <= icache_is_cached;
        end
    end

    // Beats are taken only in RECV; anything the memory side presents in
    // other states is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
            r_buf  <= '0;
        end else if (r_state == IC_REQ && rd_rdy) begin
            r_beat <= '0;
        end else if (r_state == IC_RECV && ret_valid) begin
            r_buf[r_beat] <= ret_data;
            r_beat        <= r_beat + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lru <= '0;
        end else if (w_lru_we) begin
            r_lru[w_set] <= w_lru_val;
        end
    end

endmodule
`default_nettype wire
